// File: rtl/cache_assoc_policy.sv
// N-way set-associative write-back, write-allocate cache with build-time FIFO/LRU replacement,
// invalid-way-first fill, an external line-granular memory port and saturating hit/miss counters.
module cache_assoc_policy #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned SET_ADDR_LEN  = 2,
    parameter int unsigned TAG_ADDR_LEN  = 12,
    parameter int unsigned WAY_CNT       = 4,
    parameter int unsigned POLICY        = 0,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [31:0]                             addr_i,
    input  logic                                    rd_req_i,
    input  logic                                    wr_req_i,
    input  logic [31:0]                             wr_data_i,
    output logic [31:0]                             rd_data_o,
    output logic                                    miss_o,
    output logic                                    mem_rd_req_o,
    output logic                                    mem_wr_req_o,
    output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]    mem_addr_o,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]        mem_wr_line_o,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]        mem_rd_line_i,
    input  logic                                    mem_gnt_i,
    output logic [CNT_W-1:0]                        hit_cnt_o,
    output logic [CNT_W-1:0]                        miss_cnt_o
);

    localparam int unsigned LINE_SIZE    = 2**LINE_ADDR_LEN;
    localparam int unsigned SET_SIZE     = 2**SET_ADDR_LEN;
    localparam int unsigned MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN;
    localparam int unsigned WAY_W        = $clog2(WAY_CNT);
    localparam int unsigned ADDR_TOP     = 2 + LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN;
    localparam int unsigned LINE_W       = 32 * LINE_SIZE;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StSwapOut   = 2'd1;
    localparam logic [1:0] StSwapIn    = 2'd2;
    localparam logic [1:0] StSwapInOk  = 2'd3;

    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  tag;
    logic                     unused_addr;

    assign word_idx    = addr_i[2 +: LINE_ADDR_LEN];
    assign set_idx     = addr_i[2+LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign tag         = addr_i[2+LINE_ADDR_LEN+SET_ADDR_LEN +: TAG_ADDR_LEN];
    assign unused_addr = ^{addr_i[1:0], addr_i[31:ADDR_TOP]};

    logic [31:0]             data_q  [SET_SIZE][WAY_CNT][LINE_SIZE];
    logic [TAG_ADDR_LEN-1:0] tag_q   [SET_SIZE][WAY_CNT];
    logic [WAY_CNT-1:0]      valid_q [SET_SIZE];
    logic [WAY_CNT-1:0]      dirty_q [SET_SIZE];
    logic [WAY_W-1:0]        fifo_ptr_q [SET_SIZE];
    logic [WAY_W-1:0]        age_q   [SET_SIZE][WAY_CNT];

    logic [1:0]              state_q, state_d;
    logic [WAY_W-1:0]        victim_q;
    logic [MEM_ADDR_LEN-1:0] fill_addr_q, wb_addr_q;
    logic [LINE_W-1:0]       refill_q, mem_wr_line_q;
    logic [31:0]             rd_data_q;
    logic [CNT_W-1:0]        hit_cnt_q, miss_cnt_q;
    logic                    replay_q;

    logic             hit, inv_found, victim_dirty;
    logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim;
    logic [LINE_W-1:0] victim_line;
    logic             req, wr_op, idle, hit_idle, miss_start;

    logic [SET_ADDR_LEN-1:0] fill_set;
    logic [TAG_ADDR_LEN-1:0] fill_tag;
    logic                    age_upd;
    logic [SET_ADDR_LEN-1:0] upd_set;
    logic [WAY_W-1:0]        upd_way;

    assign fill_set = fill_addr_q[SET_ADDR_LEN-1:0];
    assign fill_tag = fill_addr_q[MEM_ADDR_LEN-1:SET_ADDR_LEN];

    // Descending scans leave the lowest matching index in the result.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = int'(WAY_CNT) - 1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[set_idx][w] == WAY_W'(WAY_CNT - 1)) lru_way = WAY_W'(w);
        end
        if (inv_found)        victim = inv_way;
        else if (POLICY == 1) victim = lru_way;
        else                  victim = fifo_ptr_q[set_idx];
        victim_dirty = valid_q[set_idx][victim] & dirty_q[set_idx][victim];
        victim_line  = '0;
        for (int i = 0; i < int'(LINE_SIZE); i++) begin
            victim_line[32*i +: 32] = data_q[set_idx][victim][i];
        end
    end

    // A simultaneous read and write performs only the read.
    assign req        = rd_req_i | wr_req_i;
    assign wr_op      = wr_req_i & ~rd_req_i;
    assign idle       = (state_q == StIdle);
    assign hit_idle   = idle & req & hit;
    assign miss_start = idle & req & ~hit;
    assign miss_o     = req & ~(hit & idle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (miss_start) state_d = victim_dirty ? StSwapOut : StSwapIn;
            StSwapOut:  if (mem_gnt_i) state_d = StSwapIn;
            StSwapIn:   if (mem_gnt_i) state_d = StSwapInOk;
            StSwapInOk: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    assign age_upd = hit_idle | (state_q == StSwapInOk);
    assign upd_set = (state_q == StSwapInOk) ? fill_set : set_idx;
    assign upd_way = (state_q == StSwapInOk) ? victim_q : hit_way;

    // Data and tag storage carry no reset so they can map onto RAM.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (hit_idle && wr_op) data_q[set_idx][hit_way][word_idx] <= wr_data_i;
            if (state_q == StSwapInOk) begin
                tag_q[fill_set][victim_q] <= fill_tag;
                for (int i = 0; i < int'(LINE_SIZE); i++) begin
                    data_q[fill_set][victim_q][i] <= refill_q[32*i +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            victim_q      <= '0;
            fill_addr_q   <= '0;
            wb_addr_q     <= '0;
            refill_q      <= '0;
            mem_wr_line_q <= '0;
            rd_data_q     <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            replay_q      <= 1'b0;
            for (int s = 0; s < int'(SET_SIZE); s++) begin
                valid_q[s]    <= '0;
                dirty_q[s]    <= '0;
                fifo_ptr_q[s] <= '0;
                for (int w = 0; w < int'(WAY_CNT); w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            state_q  <= state_d;
            replay_q <= (state_q == StSwapInOk);
            if (hit_idle && rd_req_i) rd_data_q <= data_q[set_idx][hit_way][word_idx];
            if (hit_idle && wr_op) dirty_q[set_idx][hit_way] <= 1'b1;
            // The replay after a refill is the tail of a miss, not a hit.
            if (hit_idle && !replay_q && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
            if (miss_start) begin
                victim_q    <= victim;
                fill_addr_q <= {tag, set_idx};
                if (victim_dirty) begin
                    wb_addr_q     <= {tag_q[set_idx][victim], set_idx};
                    mem_wr_line_q <= victim_line;
                end
                if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
                if (POLICY == 0 && !inv_found) fifo_ptr_q[set_idx] <= fifo_ptr_q[set_idx] + 1'b1;
            end
            if (state_q == StSwapIn && mem_gnt_i) refill_q <= mem_rd_line_i;
            if (state_q == StSwapInOk) begin
                valid_q[fill_set][victim_q] <= 1'b1;
                dirty_q[fill_set][victim_q] <= 1'b0;
            end
            if (POLICY == 1 && age_upd) begin
                for (int w = 0; w < int'(WAY_CNT); w++) begin
                    if (age_q[upd_set][w] < age_q[upd_set][upd_way]) begin
                        age_q[upd_set][w] <= age_q[upd_set][w] + 1'b1;
                    end else if (WAY_W'(w) == upd_way) begin
                        age_q[upd_set][w] <= '0;
                    end
                end
            end
        end
    end

    assign rd_data_o     = rd_data_q;
    assign mem_wr_line_o = mem_wr_line_q;
    assign hit_cnt_o     = hit_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;
    assign mem_rd_req_o  = (state_q == StSwapIn);
    assign mem_wr_req_o  = (state_q == StSwapOut);
    assign mem_addr_o    = (state_q == StSwapOut) ? wb_addr_q :
                           (state_q == StSwapIn)  ? fill_addr_q : '0;

endmodule

// File: tb/tb_cache_assoc_policy.sv
// Bench for cache_assoc_policy: a FIFO instance with 4-bit counters and an LRU instance with
// 32-bit counters, each behind its own behavioural line memory.
module tb_cache_assoc_policy;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        rd_req [2];
    logic        wr_req [2];
    logic [31:0] addr [2];
    logic [31:0] wr_data [2];
    logic [31:0] rd_data [2];
    logic        miss [2];
    logic        mem_rd_req [2];
    logic        mem_wr_req [2];
    logic [13:0] mem_addr [2];
    logic [255:0] mem_wr_line [2];
    logic [255:0] mem_rd_line [2];
    logic        gnt [2];
    logic        mem_hold [2];
    logic [3:0]  hc0, mc0;
    logic [31:0] hc1, mc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_assoc_policy #(.POLICY(0), .CNT_W(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .addr_i(addr[0]), .rd_req_i(rd_req[0]),
        .wr_req_i(wr_req[0]), .wr_data_i(wr_data[0]), .rd_data_o(rd_data[0]), .miss_o(miss[0]),
        .mem_rd_req_o(mem_rd_req[0]), .mem_wr_req_o(mem_wr_req[0]), .mem_addr_o(mem_addr[0]),
        .mem_wr_line_o(mem_wr_line[0]), .mem_rd_line_i(mem_rd_line[0]), .mem_gnt_i(gnt[0]),
        .hit_cnt_o(hc0), .miss_cnt_o(mc0)
    );

    cache_assoc_policy #(.POLICY(1), .CNT_W(32)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .addr_i(addr[1]), .rd_req_i(rd_req[1]),
        .wr_req_i(wr_req[1]), .wr_data_i(wr_data[1]), .rd_data_o(rd_data[1]), .miss_o(miss[1]),
        .mem_rd_req_o(mem_rd_req[1]), .mem_wr_req_o(mem_wr_req[1]), .mem_addr_o(mem_addr[1]),
        .mem_wr_line_o(mem_wr_line[1]), .mem_rd_line_i(mem_rd_line[1]), .mem_gnt_i(gnt[1]),
        .hit_cnt_o(hc1), .miss_cnt_o(mc1)
    );

    // Behavioural main memory: untouched words follow a fixed pattern.
    logic [31:0] mstore [int];
    int          lat [2];
    int          wb_cnt [2];
    int          rd_cnt [2];
    logic [13:0] wb_addr_last [2];
    logic [31:0] wb_w0_last [2];
    logic [13:0] rd_addr_last [2];

    function automatic int key(input int d, input int la, input int w);
        return (d << 20) | (la << 3) | w;
    endfunction

    function automatic logic [31:0] mem_word(input int d, input int la, input int w);
        int k = key(d, la, w);
        if (mstore.exists(k)) return mstore[k];
        return 32'(32'h1111_1111 * w) + (32'(la) << 16);
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            gnt[d] = 1'b0;
            if (rst[d]) begin
                lat[d] = 0;
            end else if (!mem_hold[d] && (mem_rd_req[d] || mem_wr_req[d])) begin
                if (lat[d] == 0) begin
                    if (mem_wr_req[d]) begin
                        for (int i = 0; i < 8; i++)
                            mstore[key(d, int'(mem_addr[d]), i)] = mem_wr_line[d][32*i +: 32];
                        wb_cnt[d]++;
                        wb_addr_last[d] = mem_addr[d];
                        wb_w0_last[d]   = mem_wr_line[d][31:0];
                    end else begin
                        for (int i = 0; i < 8; i++)
                            mem_rd_line[d][32*i +: 32] = mem_word(d, int'(mem_addr[d]), i);
                        rd_cnt[d]++;
                        rd_addr_last[d] = mem_addr[d];
                    end
                    gnt[d] = 1'b1;
                    lat[d] = int'($urandom_range(2, 0));
                end else begin
                    lat[d]--;
                end
            end
        end
    end

    function automatic logic [31:0] hitc(input int d);
        return (d == 0) ? {28'b0, hc0} : hc1;
    endfunction

    function automatic logic [31:0] missc(input int d);
        return (d == 0) ? {28'b0, mc0} : mc1;
    endfunction

    function automatic int sat(input int d, input int x);
        return (d == 0 && x > 15) ? 15 : x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b1; rd_req[d] = 1'b0; wr_req[d] = 1'b0; mem_hold[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[d] = 1'b0;
    endtask

    // One CPU access held until accepted; returns whether it stalled and rd_data afterwards.
    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, output bit missed, output logic [31:0] rdat);
        int cyc = 0;
        @(negedge clk);
        rd_req[d] = rd; wr_req[d] = wr; addr[d] = a; wr_data[d] = wd;
        #1;
        missed = miss[d];
        while (miss[d] && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (miss[d]) chk("access_timeout", {31'b0, miss[d]}, 32'd0);
        @(posedge clk); #1;
        rdat = rd_data[d];
        rd_req[d] = 1'b0; wr_req[d] = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        bit          exp_miss;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int          exp_hit;
        int          exp_mcnt;
        int          exp_traffic;
    } vec_t;

    // Reference cache state: per-set tag order (FIFO: oldest first; LRU: most recent first).
    int          q [4][$];
    bit          dirty_m [int];
    logic [31:0] ref_wr [int];

    task automatic rand_run(input int d, input int policy, input int n);
        int hits = 0, misses = 0;
        do_reset(d);
        ref_wr.delete();
        dirty_m.delete();
        for (int s = 0; s < 4; s++) q[s].delete();
        for (int it = 0; it < n; it++) begin
            int tg = int'($urandom_range(5, 0));
            int s  = int'($urandom_range(3, 0));
            int w  = int'($urandom_range(7, 0));
            int op = int'($urandom_range(9, 0));
            bit rd = (op < 5) || (op == 9);
            bit wr = (op >= 5);
            logic [31:0] a  = 32'((tg << 7) | (s << 5) | (w << 2)) | 32'($urandom_range(3, 0));
            logic [31:0] wd = $urandom;
            int la = tg * 4 + s;
            int k  = key(d, la, w);
            int idx = -1;
            bit exp_wb = 1'b0;
            int exp_wba = 0;
            int wbb;
            bit missed;
            logic [31:0] rdat, exp_rd;
            for (int j = 0; j < q[s].size(); j++) if (q[s][j] == tg) idx = j;
            if (idx < 0) begin
                misses++;
                if (q[s].size() == 4) begin
                    int v = (policy == 1) ? q[s].pop_back() : q[s].pop_front();
                    if (dirty_m.exists(v * 4 + s)) begin
                        exp_wb  = 1'b1;
                        exp_wba = v * 4 + s;
                        dirty_m.delete(v * 4 + s);
                    end
                end
                if (policy == 1) q[s].push_front(tg);
                else q[s].push_back(tg);
            end else begin
                hits++;
                if (policy == 1) begin
                    q[s].delete(idx);
                    q[s].push_front(tg);
                end
            end
            exp_rd = ref_wr.exists(k) ? ref_wr[k] : mem_word(d, la, w);
            if (wr && !rd) begin
                dirty_m[la] = 1'b1;
                ref_wr[k]   = wd;
            end
            wbb = wb_cnt[d];
            access(d, rd, wr, a, wd, missed, rdat);
            chk("rand_miss", {31'b0, missed}, {31'b0, idx < 0});
            chk("rand_writeback", 32'(wb_cnt[d] - wbb), {31'b0, exp_wb});
            if (exp_wb) chk("rand_wb_addr", {18'b0, wb_addr_last[d]}, 32'(exp_wba));
            if (rd) chk("rand_rd_data", rdat, exp_rd);
        end
        chk("rand_hit_cnt", hitc(d), 32'(sat(d, hits)));
        chk("rand_miss_cnt", missc(d), 32'(sat(d, misses)));
    endtask

    initial begin
        vec_t        tbl [6];
        bit          missed;
        logic [31:0] rdat;
        int          base, wbb, cyc;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rd_req[d] = 1'b0; wr_req[d] = 1'b0; addr[d] = '0; wr_data[d] = '0;
            mem_hold[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_rd_data", rd_data[d], 32'd0);
            chk("reset_hit_cnt", hitc(d), 32'd0);
            chk("reset_miss_cnt", missc(d), 32'd0);
            chk("reset_mem_req", {30'b0, mem_rd_req[d], mem_wr_req[d]}, 32'd0);
            chk("reset_wr_line", {31'b0, |mem_wr_line[d]}, 32'd0);
            chk("reset_miss", {31'b0, miss[d]}, 32'd0);
        end

        // Cold read, write hit, read hit, read+write collision, off-set cold read.
        tbl[0] = '{1, 0, 32'h004, 32'h0,        1, 1, 32'h1111_1111, 0, 1, 1};
        tbl[1] = '{0, 1, 32'h004, 32'hDEADBEEF, 0, 0, 32'h0,         1, 1, 1};
        tbl[2] = '{1, 0, 32'h004, 32'h0,        0, 1, 32'hDEADBEEF,  2, 1, 1};
        tbl[3] = '{1, 1, 32'h004, 32'h0,        0, 1, 32'hDEADBEEF,  3, 1, 1};
        tbl[4] = '{1, 0, 32'h004, 32'h0,        0, 1, 32'hDEADBEEF,  4, 1, 1};
        tbl[5] = '{1, 0, 32'h024, 32'h0,        1, 1, 32'h1112_1111, 4, 2, 2};
        base = rd_cnt[1] + wb_cnt[1];
        for (int i = 0; i < 6; i++) begin
            access(1, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, missed, rdat);
            chk($sformatf("vec%0d_miss", i), {31'b0, missed}, {31'b0, tbl[i].exp_miss});
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd_data", i), rdat, tbl[i].exp_rd);
            chk($sformatf("vec%0d_hit_cnt", i), hitc(1), 32'(tbl[i].exp_hit));
            chk($sformatf("vec%0d_miss_cnt", i), missc(1), 32'(tbl[i].exp_mcnt));
            chk($sformatf("vec%0d_traffic", i), 32'(rd_cnt[1] + wb_cnt[1] - base),
                32'(tbl[i].exp_traffic));
        end
        chk("refill_addr_set1", {18'b0, rd_addr_last[1]}, 32'h1);

        // FIFO: way 0 (tag 0, dirty) is the oldest once the set is full.
        do_reset(0);
        for (int t = 0; t < 4; t++) access(0, 1, 0, 32'(t * 32'h80), 32'h0, missed, rdat);
        access(0, 0, 1, 32'h000, 32'hA5A5A5A5, missed, rdat);
        wbb = wb_cnt[0];
        access(0, 1, 0, 32'h200, 32'h0, missed, rdat);
        chk("fifo_evict_miss", {31'b0, missed}, 32'd1);
        chk("fifo_wb_count", 32'(wb_cnt[0] - wbb), 32'd1);
        chk("fifo_wb_addr", {18'b0, wb_addr_last[0]}, 32'h000);
        chk("fifo_wb_word0", wb_w0_last[0], 32'hA5A5A5A5);
        chk("fifo_refill_addr", {18'b0, rd_addr_last[0]}, 32'h010);
        chk("fifo_refill_data", rdat, 32'h0010_0000);
        access(0, 1, 0, 32'h000, 32'h0, missed, rdat);
        chk("fifo_old_line_miss", {31'b0, missed}, 32'd1);
        chk("fifo_old_line_data", rdat, 32'hA5A5A5A5);

        // LRU: touching tag 0 makes tag 1 the least recent.
        do_reset(1);
        for (int t = 0; t < 4; t++) access(1, 1, 0, 32'(t * 32'h80), 32'h0, missed, rdat);
        access(1, 1, 0, 32'h000, 32'h0, missed, rdat);
        chk("lru_touch_hit", {31'b0, missed}, 32'd0);
        wbb = wb_cnt[1];
        access(1, 1, 0, 32'h200, 32'h0, missed, rdat);
        chk("lru_evict_miss", {31'b0, missed}, 32'd1);
        chk("lru_no_writeback", 32'(wb_cnt[1] - wbb), 32'd0);
        access(1, 1, 0, 32'h000, 32'h0, missed, rdat);
        chk("lru_tag0_kept", {31'b0, missed}, 32'd0);
        access(1, 1, 0, 32'h080, 32'h0, missed, rdat);
        chk("lru_tag1_evicted", {31'b0, missed}, 32'd1);

        rand_run(0, 0, 300);
        rand_run(1, 1, 300);

        // Reset while a write-back is pending abandons it.
        do_reset(0);
        access(0, 1, 0, 32'h000, 32'h0, missed, rdat);
        access(0, 0, 1, 32'h000, 32'h1234_5678, missed, rdat);
        for (int t = 1; t < 4; t++) access(0, 1, 0, 32'(t * 32'h80), 32'h0, missed, rdat);
        @(negedge clk);
        mem_hold[0] = 1'b1; rd_req[0] = 1'b1; addr[0] = 32'h200;
        cyc = 0;
        while (!mem_wr_req[0] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("swap_out_reached", {31'b0, mem_wr_req[0]}, 32'd1);
        @(negedge clk);
        rst[0] = 1'b1; rd_req[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_wr_req", {31'b0, mem_wr_req[0]}, 32'd0);
        chk("rst_mid_rd_req", {31'b0, mem_rd_req[0]}, 32'd0);
        chk("rst_mid_hit_cnt", hitc(0), 32'd0);
        chk("rst_mid_miss_cnt", missc(0), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0; mem_hold[0] = 1'b0;
        access(0, 1, 0, 32'h000, 32'h0, missed, rdat);
        chk("post_rst_miss", {31'b0, missed}, 32'd1);
        for (int k = 1; k <= 20; k++) begin
            access(0, 1, 0, 32'h000, 32'h0, missed, rdat);
            if (k == 14) chk("hit_cnt_14", hitc(0), 32'd14);
            if (k == 15) chk("hit_cnt_15", hitc(0), 32'd15);
        end
        chk("hit_cnt_saturated", hitc(0), 32'd15);
        chk("sat_miss_cnt", missc(0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_assoc_policy.md
Name: cache_assoc_policy

Overview:
Parametrised N-way set-associative write-back, write-allocate cache with a replacement policy selectable at build time (FIFO or true LRU). It adds invalid-way-first fill and saturating hit/miss statistics counters. Sits between the CPU data port (word granularity, miss stall) and a line-granular main memory. Unlike the earlier cache, the memory port is external, so the block can drive any main_mem instance.

Parameters:
LINE_ADDR_LEN, 3, log2 words per line (LINE_SIZE = 2^LINE_ADDR_LEN)
SET_ADDR_LEN, 2, log2 set count (SET_SIZE = 2^SET_ADDR_LEN)
TAG_ADDR_LEN, 12, tag width; MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN
WAY_CNT, 4, associativity; power of two, >= 2
POLICY, 0, replacement policy: 0 = FIFO, 1 = LRU
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  32  byte address: [1:0] word offset ignored; then line, set, tag fields; upper bits ignored
rd_req  in  1  read request; held by CPU while miss=1
wr_req  in  1  write request; held by CPU while miss=1
wr_data  in  32  write word
rd_data  out  32  read word, registered
miss  out  1  stall: (rd_req|wr_req) & ~(hit & state==IDLE)
mem_rd_req  out  1  line read request, level
mem_wr_req  out  1  line write-back request, level
mem_addr  out  MEM_ADDR_LEN  line address {tag,set}; 0 when no request
mem_wr_line  out  32*LINE_SIZE  write-back line, word i at [32i+31:32i]
mem_rd_line  in  32*LINE_SIZE  refill line, valid in the cycle mem_gnt=1
mem_gnt  in  1  one-cycle completion pulse from memory
hit_cnt  out  CNT_W  accesses serviced without a refill
miss_cnt  out  CNT_W  misses started

Behaviour:
- Reset (rst sampled high at clk edge):
  - State goes to IDLE.
  - All valid and dirty bits clear.
  - FIFO pointers are 0. LRU age of way w is w.
  - rd_data, mem_wr_line, hit_cnt and miss_cnt are 0; mem_rd_req and mem_wr_req are 0.
  - Data and tag arrays are not reset.
  - Reset mid-transaction abandons the transaction.
- Lookup (combinational): hit when some valid way in the set has a matching tag. If several match, the lowest index is used.
- Simultaneous rd_req and wr_req: the read is performed and the write is dropped.
- IDLE, read hit: rd_data gets the word on the next edge.
- IDLE, write hit: the word is written and the way's dirty bit is set.
- IDLE, any request that misses:
  - Select the victim: the lowest-index invalid way if one exists; otherwise the policy victim.
  - Latch the victim way, the refill address {tag,set} and, if the victim is valid and dirty, the write-back address {victim tag,set} and the victim line into mem_wr_line.
  - Next state is SWAP_OUT if the victim is valid and dirty, else SWAP_IN.
  - miss_cnt increments.
- SWAP_OUT: mem_wr_req=1, mem_addr=write-back address; on mem_gnt go to SWAP_IN.
- SWAP_IN: mem_rd_req=1, mem_addr=refill address; on mem_gnt capture mem_rd_line and go to SWAP_IN_OK.
- SWAP_IN_OK (1 cycle): write the line, tag, valid=1 and dirty=0 into the latched way, then go to IDLE. The held request replays as a hit the next cycle.
- Minimum miss penalty: 3 cycles plus memory latency. A write-back adds its own memory latency.
- hit_cnt increments on each IDLE hit cycle with a request, except the replay cycle directly after SWAP_IN_OK. Both counters saturate at all-ones.
- FIFO policy: each set keeps a pointer.
  - Policy victim = way at the pointer; the pointer then advances mod WAY_CNT.
  - Invalid-way fills do not move the pointer. Sequential fill from way 0 keeps way 0 as the oldest.
- LRU policy: each set keeps per-way ages, clog2(WAY_CNT) bits each, always a permutation of 0..WAY_CNT-1.
  - On a hit or a fill of way w: every way with age < age[w] increments, then age[w] becomes 0.
  - Policy victim = the way with age WAY_CNT-1.
- Request changes while miss=1 are illegal. The cache completes the latched refill and then re-evaluates.

Test Plan:
(Defaults; addresses 0x000, 0x080, 0x100, 0x180 and 0x200 all map to set 0 with tags 0, 1, 2, 3 and 4.)
1. Cold read 0x004, memory line word1=0x11111111 -> miss=1; mem_rd_req with mem_addr=0x000; after gnt and SWAP_IN_OK, miss=0 and rd_data=0x11111111 on the next edge; miss_cnt=1, hit_cnt=0.
2. Write 0x004 = 0xDEADBEEF (hit), then read 0x004 -> rd_data=0xDEADBEEF, no memory traffic, hit_cnt=2.
3. POLICY=0: read 0x000, 0x080, 0x100, 0x180; write 0x000=0xA5A5A5A5; read 0x200 -> SWAP_OUT with mem_addr=0x000 and mem_wr_line word0=0xA5A5A5A5, then SWAP_IN with mem_addr=0x010; a later read of 0x000 misses.
4. POLICY=1: same four fills; read 0x000 (hit); read 0x200 -> no SWAP_OUT, way 1 (tag 1) evicted; 0x000 still hits and 0x080 misses.
5. Simultaneous rd_req and wr_req at hit address 0x004 with wr_data=0x0 -> rd_data holds the old value and the stored word is unchanged.
6. Assert rst during SWAP_OUT -> next cycle mem_wr_req=0, counters 0; read 0x000 misses. With CNT_W=4, 20 hits give hit_cnt=15.
